// File: rtl/uart_cmd_decoder.sv
// Decodes framed command bytes from a show-ahead RX FIFO into address/data write requests.
// Address frames set the target address; data frames issue a write held until accepted.
module uart_cmd_decoder #(
  parameter int         WORD_BYTES  = 4,
  parameter int         USEDW_W     = 7,
  parameter logic [7:0] ADDR_HDR    = 8'hCC,
  parameter logic [7:0] DATA_HDR    = 8'hF3,
  parameter int         TIMEOUT_CYC = 1024,
  parameter bit         AUTO_INC    = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                i_uart_byte,
  input  logic                      i_FIFO_empty,
  input  logic [USEDW_W-1:0]        i_FIFO_usedw,
  output logic                      o_FIFO_rdreq,
  output logic [8*WORD_BYTES-1:0]   o_proc_addr,
  output logic [8*WORD_BYTES-1:0]   o_proc_data,
  output logic                      o_wren,
  input  logic                      i_wr_ready,
  output logic                      o_error,
  output logic [1:0]                o_err_code
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_byteCnt;
  logic [TMO_W-1:0]   r_tmo;
  logic [W-1:0]       r_shift;
  logic [W-1:0]       r_addr;
  logic [W-1:0]       r_data;
  logic               r_addrValid;
  logic               r_wren;
  logic               r_error;
  logic [1:0]         r_errCode;

  logic               w_pop;
  logic               w_last;
  logic               w_tmoHit;
  logic               w_errSet;
  logic [1:0]         w_errVal;
  logic [W+7:0]       w_cat;
  logic [W-1:0]       w_word;

  // Fill level is status only; folded into an unused sink.
  logic               w_unusedUsedw;
  assign w_unusedUsedw = ^i_FIFO_usedw;

  // The word completed by the current byte, MSB first.
  assign w_cat    = {r_shift, i_uart_byte};
  assign w_word   = w_cat[W-1:0];
  assign w_last   = (r_byteCnt == CNT_W'(WORD_BYTES - 1));
  assign w_tmoHit = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_errSet = 1'b0;
    w_errVal = 2'd0;
    case (r_state)
      IDLE: begin
        if (!i_FIFO_empty) begin
          w_pop = 1'b1;
          if (i_uart_byte == ADDR_HDR) begin
            w_next = RD_ADDR;
          end else if (i_uart_byte == DATA_HDR) begin
            w_next = RD_DATA;
          end else begin
            w_errSet = 1'b1;
            w_errVal = 2'd1;
          end
        end
      end
      RD_ADDR, RD_DATA: begin
        if (!i_FIFO_empty) begin
          w_pop = 1'b1;
          if (w_last) begin
            if (r_state == RD_ADDR) begin
              w_next = IDLE;
            end else if (r_addrValid) begin
              w_next = WRITE;
            end else begin
              w_next   = IDLE;
              w_errSet = 1'b1;
              w_errVal = 2'd2;
            end
          end
        end else if (w_tmoHit) begin
          w_next   = IDLE;
          w_errSet = 1'b1;
          w_errVal = 2'd3;
        end
      end
      WRITE: begin
        if (r_wren && i_wr_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, frame assembly, timeout and write handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_byteCnt   <= '0;
      r_tmo       <= '0;
      r_shift     <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_addrValid <= 1'b0;
      r_wren      <= 1'b0;
      r_error     <= 1'b0;
      r_errCode   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_error <= w_errSet;
      if (w_errSet) begin
        r_errCode <= w_errVal;
      end

      if (r_state == RD_ADDR || r_state == RD_DATA) begin
        if (w_pop) begin
          r_tmo     <= '0;
          r_shift   <= w_word;
          r_byteCnt <= w_last ? '0 : r_byteCnt + CNT_W'(1);
        end else if (w_tmoHit) begin
          r_tmo     <= '0;
          r_byteCnt <= '0;
        end else begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
      end else begin
        r_tmo     <= '0;
        r_byteCnt <= '0;
      end

      if (r_state == RD_ADDR && w_pop && w_last) begin
        r_addr      <= w_word;
        r_addrValid <= 1'b1;
      end

      if (r_state == RD_DATA && w_pop && w_last && r_addrValid) begin
        r_data <= w_word;
        r_wren <= 1'b1;
      end

      // Acceptance either advances the address (wrapping) or retires it.
      if (r_state == WRITE && r_wren && i_wr_ready) begin
        r_wren <= 1'b0;
        if (AUTO_INC) begin
          r_addr <= r_addr + W'(WORD_BYTES);
        end else begin
          r_addrValid <= 1'b0;
        end
      end
    end
  end

  assign o_FIFO_rdreq = w_pop && !reset;
  assign o_proc_addr  = r_addr;
  assign o_proc_data  = r_data;
  assign o_wren       = r_wren;
  assign o_error      = r_error;
  assign o_err_code   = r_errCode;

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4: bytes per address/data word; word width W = 8*WORD_BYTES.
REQ-002 SHALL have parameter USEDW_W, default 7: width of the FIFO fill-level input.
REQ-003 SHALL have parameter ADDR_HDR, default 8'hCC: header byte that opens an address frame.
REQ-004 SHALL have parameter DATA_HDR, default 8'hF3: header byte that opens a data frame.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024: maximum idle cycles allowed inside a frame.
REQ-006 SHALL have parameter AUTO_INC, default 1: after each accepted write, 1 = increment the address, 0 = invalidate it.
REQ-007 SHALL have port clk, input, 1: the single clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-009 SHALL have port i_uart_byte, input, 8: head byte of a show-ahead RX FIFO; valid whenever i_FIFO_empty=0.
REQ-010 SHALL have port i_FIFO_empty, input, 1: RX FIFO empty flag.
REQ-011 SHALL have port i_FIFO_usedw, input, USEDW_W: FIFO fill level; status only, not used by the logic.
REQ-012 SHALL have port o_FIFO_rdreq, output, 1: one-cycle pop of the head byte.
REQ-013 SHALL have port o_proc_addr, output, W: write address.
REQ-014 SHALL have port o_proc_data, output, W: write data.
REQ-015 SHALL have port o_wren, output, 1: write request, held until accepted.
REQ-016 SHALL have port i_wr_ready, input, 1: write sink accepts the request this cycle.
REQ-017 SHALL have port o_error, output, 1: one-cycle error pulse.
REQ-018 SHALL have port o_err_code, output, 2: last error code; 1 = bad header, 2 = data frame with no valid address, 3 = timeout.

Function
REQ-019 SHALL have states IDLE, RD_ADDR, RD_DATA, WRITE.
REQ-020 SHALL assert o_FIFO_rdreq only when i_FIFO_empty=0, and only in the cycle the head byte is consumed; at most one byte per cycle; never in WRITE.
REQ-021 In IDLE, on a non-empty FIFO, SHALL pop the header: ADDR_HDR -> RD_ADDR; DATA_HDR -> RD_DATA; any other byte -> dropped, error code 1, stay in IDLE.
REQ-022 In RD_ADDR / RD_DATA, SHALL consume WORD_BYTES bytes, MSB first, into a shift buffer, using a byte counter 0..WORD_BYTES-1.
REQ-023 On the last address byte, SHALL load the address register, set addr_valid, go to IDLE; o_proc_addr updates on the next edge.
REQ-024 On the last data byte with addr_valid=1, SHALL load o_proc_data, assert o_wren on the next edge, go to WRITE.
REQ-025 On the last data byte with addr_valid=0, SHALL discard the word, raise error code 2, go to IDLE.
REQ-026 In WRITE, SHALL hold o_wren=1 with o_proc_addr and o_proc_data stable until i_wr_ready=1 in a cycle with o_wren=1; on that edge: o_wren=0, go to IDLE.
REQ-027 On write acceptance with AUTO_INC=1, SHALL set address += WORD_BYTES, modulo 2^W (all-ones + WORD_BYTES wraps), keeping addr_valid=1.
REQ-028 On write acceptance with AUTO_INC=0, SHALL clear addr_valid.
REQ-029 i_wr_ready outside WRITE SHALL have no effect.
REQ-030 In RD_ADDR / RD_DATA, a timeout counter SHALL reset on every consumed byte and count every other cycle.
REQ-031 On reaching TIMEOUT_CYC, SHALL discard the partial word, raise error code 3, go to IDLE; addr_valid is unchanged.
REQ-032 An error SHALL pulse o_error for exactly one cycle and load o_err_code, which holds until the next error.
REQ-033 Latency: data frame with all bytes present -> header pop at cycle 0, bytes at cycles 1..WORD_BYTES, o_wren=1 at cycle WORD_BYTES+1.
REQ-034 Back-to-back frames SHALL require no idle gap beyond the WRITE handshake.
REQ-035 An address frame arriving while addr_valid=1 SHALL overwrite the address.

Reset
REQ-036 On reset=1 at a clock edge, SHALL apply: state=IDLE, byte counter=0, timeout counter=0, addr_valid=0, o_FIFO_rdreq=0, o_wren=0, o_error=0, o_err_code=0, o_proc_addr=0, o_proc_data=0.
REQ-037 Reset mid-frame or in WRITE SHALL discard the partial frame or pending write with no write issued; FIFO contents are untouched.

Verification
REQ-038 Bench SHALL cover: bytes CC 00 00 10 00 F3 DE AD BE EF with i_wr_ready=1 -> one write, addr 0x00001000, data 0xDEADBEEF; 10 pops total; o_wren high exactly 1 cycle.
REQ-039 Bench SHALL cover: AUTO_INC=1, bytes CC FF FF FF FC then two data frames -> writes at 0xFFFFFFFC and then 0x00000000 (wrap).
REQ-040 Bench SHALL cover: byte 55 in IDLE -> o_error pulse, o_err_code=1, no write; a following valid frame is decoded normally.
REQ-041 Bench SHALL cover: after reset, F3 11 22 33 44 -> o_err_code=2, no o_wren; with AUTO_INC=0, a second data frame after a write also -> code 2.
REQ-042 Bench SHALL cover: CC 12 then FIFO empty for TIMEOUT_CYC cycles -> code 3, back to IDLE; i_wr_ready held 0 for 7 cycles in WRITE -> o_wren, addr, data stable for all 7 cycles and no FIFO pops.
